// File: rtl/rd_ctrl.sv
// Read-side controller of the asynchronous FIFO (rd_clk domain): owns the read pointer,
// synchronizes the write Gray pointer and produces registered empty/level flags.
module rd_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_in,
  input  logic                  rd_en_sys,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] rd_ptr_ram,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_valid,
  output logic                  underflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AeThresh = PW'(AEMPTY_THRESH);

  logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] sync_q;
  logic [ADDR_WIDTH:0] wr_gray_sync;
  logic [ADDR_WIDTH:0] wr_bin_sync;
  logic [ADDR_WIDTH:0] rd_ptr_bin;
  logic [ADDR_WIDTH:0] rd_bin_next;
  logic [ADDR_WIDTH:0] rd_gray_next;
  logic [ADDR_WIDTH:0] level_next;

  // XOR prefix from the MSB down.
  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = int'(ADDR_WIDTH) - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign wr_gray_sync = sync_q[SYNC_STAGES-1];
  assign wr_bin_sync  = gray2bin(wr_gray_sync);
  assign ram_ren      = rd_en_sys & ~empty;
  assign rd_bin_next  = rd_ptr_bin + {{ADDR_WIDTH{1'b0}}, ram_ren};
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
  assign level_next   = wr_bin_sync - rd_bin_next;
  assign rd_ptr_ram   = rd_ptr_bin[ADDR_WIDTH-1:0];

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wr_ptr_gray_in};
    end
  end

  // Flags are registered from next-state values so a read shows up at its own edge.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_bin   <= '0;
      rd_ptr_gray  <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      rd_ptr_bin   <= rd_bin_next;
      rd_ptr_gray  <= rd_gray_next;
      empty        <= (rd_gray_next == wr_gray_sync);
      almost_empty <= (level_next <= AeThresh);
      rd_level     <= level_next;
      rd_valid     <= ram_ren;
      underflow    <= underflow | (rd_en_sys & empty);
    end
  end

endmodule

// File: tb/tb_rd_ctrl.sv
// Scoreboard bench for rd_ctrl with default parameters (ADDR_WIDTH=4, SYNC_STAGES=2).
module tb_rd_ctrl;

  logic       rd_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] wr_ptr_gray_in = '0;
  logic       rd_en_sys = 1'b0;
  logic       ram_ren;
  logic [3:0] rd_ptr_ram;
  logic [4:0] rd_ptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_level;
  logic       rd_valid;
  logic       underflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] addr_q[$];
  logic [4:0] gray_q[$];
  bit         valid_q[$];

  rd_ctrl dut (
    .rd_clk        (rd_clk),
    .rst_n         (rst_n),
    .wr_ptr_gray_in(wr_ptr_gray_in),
    .rd_en_sys     (rd_en_sys),
    .ram_ren       (ram_ren),
    .rd_ptr_ram    (rd_ptr_ram),
    .rd_ptr_gray   (rd_ptr_gray),
    .empty         (empty),
    .almost_empty  (almost_empty),
    .rd_level      (rd_level),
    .rd_valid      (rd_valid),
    .underflow     (underflow)
  );

  always #5 rd_clk = ~rd_clk;

  function automatic logic [4:0] g(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] exp_rst;
    exp_rst = {1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0};
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({empty, almost_empty, rd_level, rd_ptr_gray, rd_valid, underflow, ram_ren, rd_ptr_ram}
        !== exp_rst) begin
      n_bad++;
      $display("FAIL reset_initial: got %h want %h",
               {empty, almost_empty, rd_level, rd_ptr_gray, rd_valid, underflow, ram_ren,
                rd_ptr_ram}, exp_rst);
    end
    @(negedge rd_clk) rst_n = 1'b1;
    tick();
    rd_en_sys = 1'b1;
    #1;
    n_cmp++;
    if (ram_ren !== 1'b0) begin
      n_bad++; $display("FAIL reject_when_empty: ram_ren got %b want 0", ram_ren);
    end
    tick();
    rd_en_sys = 1'b0;
    n_cmp++;
    if ({underflow, rd_ptr_gray} !== {1'b1, 5'd0}) begin
      n_bad++; $display("FAIL underflow_set: got uf=%b gray=%b want 1/00000", underflow, rd_ptr_gray);
    end
    wr_ptr_gray_in = 5'b00010;
    repeat (3) tick();
    rd_en_sys = 1'b1;
    tick();
    n_cmp++;
    if ({rd_valid, rd_ptr_gray, rd_level} !== {1'b1, 5'b00001, 5'd2}) begin
      n_bad++;
      $display("FAIL pre_reset_state: got valid=%b gray=%b lvl=%0d want 1/00001/2",
               rd_valid, rd_ptr_gray, rd_level);
    end
    // Assert reset mid-cycle with a read in flight; clearing must not wait for a clock.
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({empty, almost_empty, rd_level, rd_ptr_gray, rd_valid, underflow, ram_ren, rd_ptr_ram}
        !== exp_rst) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h",
               {empty, almost_empty, rd_level, rd_ptr_gray, rd_valid, underflow, ram_ren,
                rd_ptr_ram}, exp_rst);
    end
    rd_en_sys      = 1'b0;
    wr_ptr_gray_in = '0;
    @(negedge rd_clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sync_latency();
    wr_ptr_gray_in = 5'b00001;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_cmp++;
      if (e < 2) begin
        if ({empty, rd_level} !== {1'b1, 5'd0}) begin
          n_bad++; $display("FAIL sync_early_%0d: got e=%b lvl=%0d want 1/0", e, empty, rd_level);
        end
      end else if ({empty, almost_empty, rd_level} !== {1'b0, 1'b1, 5'd1}) begin
        n_bad++;
        $display("FAIL sync_arrive: got e=%b ae=%b lvl=%0d want 0/1/1",
                 empty, almost_empty, rd_level);
      end
    end
  endtask

  task automatic test_drain();
    int  ptr;
    int  lvl;
    bit  uf;
    bit  exp_acc;
    bit  v;
    logic [3:0] a;
    logic [4:0] lv;
    ptr = 0; lvl = 3; uf = 1'b0;
    wr_ptr_gray_in = 5'b00010;
    repeat (3) tick();
    n_cmp++;
    if ({empty, almost_empty, rd_level} !== {1'b0, 1'b0, 5'd3}) begin
      n_bad++;
      $display("FAIL drain_start: got e=%b ae=%b lvl=%0d want 0/0/3", empty, almost_empty, rd_level);
    end
    rd_en_sys = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      exp_acc = (lvl != 0);
      if (exp_acc) addr_q.push_back(4'(ptr));
      valid_q.push_back(exp_acc);
      n_cmp++;
      if (ram_ren !== exp_acc) begin
        n_bad++; $display("FAIL drain_ren_%0d: got %b want %b", c, ram_ren, exp_acc);
      end
      if (ram_ren === 1'b1 && addr_q.size() > 0) begin
        a = addr_q.pop_front();
        n_cmp++;
        if (rd_ptr_ram !== a) begin
          n_bad++; $display("FAIL drain_addr_%0d: got %0d want %0d", c, rd_ptr_ram, a);
        end
      end
      tick();
      if (exp_acc) begin ptr++; lvl--; end else uf = 1'b1;
      v = valid_q.pop_front();
      n_cmp++;
      if (rd_valid !== v) begin
        n_bad++; $display("FAIL drain_valid_%0d: got %b want %b", c, rd_valid, v);
      end
      lv = 5'(lvl);
      n_cmp++;
      if ({empty, almost_empty, rd_level, underflow} !== {lvl == 0, lvl <= 2, lv, uf}) begin
        n_bad++;
        $display("FAIL drain_flags_%0d: got e=%b ae=%b lvl=%0d uf=%b want %b/%b/%0d/%b", c,
                 empty, almost_empty, rd_level, underflow, lvl == 0, lvl <= 2, lvl, uf);
      end
    end
    addr_q.delete();
    rd_en_sys = 1'b0;
    tick();
    n_cmp++;
    if ({rd_valid, underflow, empty, rd_level} !== {1'b0, 1'b1, 1'b1, 5'd0}) begin
      n_bad++;
      $display("FAIL drain_end: got v=%b uf=%b e=%b lvl=%0d want 0/1/1/0",
               rd_valid, underflow, empty, rd_level);
    end
  endtask

  task automatic test_wrap();
    int ptr;
    logic [3:0] a;
    logic [4:0] gr;
    ptr = 3;
    rd_en_sys = 1'b1;
    for (int w = 4; w <= 32; w++) begin
      wr_ptr_gray_in = g(w);
      addr_q.push_back(4'(ptr));
      gray_q.push_back(g(ptr + 1));
      tick();
      tick();
      n_cmp++;
      if (empty !== 1'b1) begin
        n_bad++; $display("FAIL wrap_wait_w%0d: empty got %b want 1", w, empty);
      end
      tick();
      n_cmp++;
      if ({empty, rd_level, ram_ren} !== {1'b0, 5'd1, 1'b1}) begin
        n_bad++;
        $display("FAIL wrap_avail_w%0d: got e=%b lvl=%0d ren=%b want 0/1/1",
                 w, empty, rd_level, ram_ren);
      end
      a = addr_q.pop_front();
      n_cmp++;
      if (rd_ptr_ram !== a) begin
        n_bad++; $display("FAIL wrap_addr_w%0d: got %0d want %0d", w, rd_ptr_ram, a);
      end
      tick();
      gr = gray_q.pop_front();
      n_cmp++;
      if ({empty, rd_level, rd_valid, rd_ptr_gray} !== {1'b1, 5'd0, 1'b1, gr}) begin
        n_bad++;
        $display("FAIL wrap_read_w%0d: got e=%b lvl=%0d v=%b gray=%b want 1/0/1/%b",
                 w, empty, rd_level, rd_valid, rd_ptr_gray, gr);
      end
      ptr++;
    end
    rd_en_sys = 1'b0;
    tick();
  endtask

  task automatic test_full_level();
    wr_ptr_gray_in = 5'b11000;
    repeat (3) tick();
    n_cmp++;
    if ({empty, almost_empty, rd_level, rd_ptr_gray} !== {1'b0, 1'b0, 5'd16, 5'd0}) begin
      n_bad++;
      $display("FAIL full_level: got e=%b ae=%b lvl=%0d gray=%b want 0/0/16/00000",
               empty, almost_empty, rd_level, rd_ptr_gray);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] a;
    logic [4:0] gr;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({underflow, rd_level, empty} !== {1'b0, 5'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL sim_reset: got uf=%b lvl=%0d e=%b want 0/0/1", underflow, rd_level, empty);
    end
    wr_ptr_gray_in = '0;
    @(negedge rd_clk) rst_n = 1'b1;
    tick();
    wr_ptr_gray_in = g(2);
    repeat (3) tick();
    wr_ptr_gray_in = g(3);
    tick();
    tick();
    n_cmp++;
    if ({empty, rd_level} !== {1'b0, 5'd2}) begin
      n_bad++; $display("FAIL sim_before: got e=%b lvl=%0d want 0/2", empty, rd_level);
    end
    // Read lands on the edge where the synchronized write advance enters the level.
    rd_en_sys = 1'b1;
    addr_q.push_back(4'd0);
    gray_q.push_back(g(1));
    #1;
    a = addr_q.pop_front();
    n_cmp++;
    if ({ram_ren, rd_ptr_ram} !== {1'b1, a}) begin
      n_bad++; $display("FAIL sim_accept: got ren=%b addr=%0d want 1/%0d", ram_ren, rd_ptr_ram, a);
    end
    tick();
    rd_en_sys = 1'b0;
    gr = gray_q.pop_front();
    n_cmp++;
    if ({empty, rd_level, rd_valid, rd_ptr_gray} !== {1'b0, 5'd2, 1'b1, gr}) begin
      n_bad++;
      $display("FAIL sim_same_cycle: got e=%b lvl=%0d v=%b gray=%b want 0/2/1/%b",
               empty, rd_level, rd_valid, rd_ptr_gray, gr);
    end
    tick();
    n_cmp++;
    if ({empty, rd_level, rd_valid} !== {1'b0, 5'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL sim_after: got e=%b lvl=%0d v=%b want 0/2/0", empty, rd_level, rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_drain();
    test_wrap();
    test_full_level();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rd_ctrl.md
Name: rd_ctrl

Overview:
Read-side controller of the asynchronous FIFO, in the rd_clk domain. It is the counterpart of the write controller.
- Owns the read pointer and drives RAM read enable and address.
- Synchronizes the write-domain Gray pointer into rd_clk and generates registered empty, almost_empty and fill-level flags.
- Exports its own Gray read pointer for the write side's full logic.

Parameters:
ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH; extended pointers are ADDR_WIDTH+1 bits.
SYNC_STAGES, 2, flops in the write-pointer synchronizer chain; legal values are 2 or greater.
AEMPTY_THRESH, 2, almost_empty asserts when rd_level <= AEMPTY_THRESH.

Ports:
rd_clk  input  1  read-domain clock; all flops on rising edge.
rst_n  input  1  asynchronous active-low reset. Assertion takes effect immediately; deassertion is synchronous to rd_clk.
wr_ptr_gray_in  input  ADDR_WIDTH+1  Gray-coded extended write pointer from the write domain; asynchronous to rd_clk.
rd_en_sys  input  1  read request from the system.
ram_ren  output  1  RAM read enable; equals rd_en_sys & ~empty.
rd_ptr_ram  output  ADDR_WIDTH  RAM read address; equals the low ADDR_WIDTH bits of the binary read pointer.
rd_ptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
empty  output  1  registered empty flag.
almost_empty  output  1  registered; asserted when rd_level <= AEMPTY_THRESH.
rd_level  output  ADDR_WIDTH+1  registered conservative fill level, 0..2**ADDR_WIDTH.
rd_valid  output  1  high one cycle after each accepted read, marking RAM output data valid (RAM read latency is 1).
underflow  output  1  sticky; set on a read attempt while empty.

Behaviour:
- Reset values: rd_ptr_bin=0, rd_ptr_gray=0, all synchronizer stages=0, empty=1, almost_empty=1, rd_level=0, rd_valid=0, underflow=0. Reset asserted mid-operation clears all of these at once; any read in flight is dropped.
- Synchronizer: a chain of SYNC_STAGES flops on wr_ptr_gray_in; only the last stage (wr_gray_sync) is used. wr_bin_sync = gray-to-binary(wr_gray_sync), computed with an XOR prefix from the MSB.
- Read accept: ram_ren = rd_en_sys & ~empty, combinational from the registered empty flag.
- Pointer update:
  - rd_bin_next = rd_ptr_bin + ram_ren, modulo 2**(ADDR_WIDTH+1). The extra MSB toggles on each wrap.
  - rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
  - Both rd_ptr_bin and rd_ptr_gray are registered. rd_ptr_gray is taken straight from a flop, so it is glitch-free and changes by at most one bit per cycle.
- empty <= (rd_gray_next == wr_gray_sync). The compare uses the full ADDR_WIDTH+1 bits, so a wrapped pointer never reads as empty falsely.
- rd_level <= (wr_bin_sync - rd_bin_next), modulo 2**(ADDR_WIDTH+1). Invariant: empty==1 iff rd_level==0, in every cycle.
- almost_empty <= (wr_bin_sync - rd_bin_next) <= AEMPTY_THRESH.
- rd_valid <= ram_ren. Exactly one rd_valid pulse per accepted read, delayed by 1 cycle.
- underflow <= underflow | (rd_en_sys & empty). Cleared only by reset. The pointer never moves on a rejected read.
- Latency:
  - A write-pointer change stable before rd_clk edge k reaches wr_gray_sync at edge k+SYNC_STAGES-1.
  - empty, rd_level and almost_empty reflect it at edge k+SYNC_STAGES. With the default, that is the 2nd edge.
  - A read accepted at edge n shows in empty, rd_level and rd_ptr_gray at edge n (registered from the next-state values).
- Simultaneous read and synchronized write advance in the same cycle: both terms enter the same rd_level and empty computation, so the net level is unchanged.
- Flags are pessimistic: empty may stay high extra cycles after a write; it never deasserts early.

Test Plan:
1. Reset: drive rst_n low between clock edges with state nonzero -> empty=1, almost_empty=1, rd_level=0, rd_ptr_gray=0, rd_valid=0, underflow=0 immediately, with no clock needed.
2. Sync latency: wr_ptr_gray_in 00000->00001, stable before edge k -> empty falls and rd_level=1 at edge k+2 (SYNC_STAGES=2); no change at edge k+1.
3. Drain: wr_ptr_gray_in=00010 (bin 3), rd_en_sys held 5 cycles ->
   - ram_ren high 3 cycles with rd_ptr_ram 0,1,2;
   - rd_valid high the 3 following cycles;
   - rd_level 3->2->1->0, with almost_empty high from level 2;
   - empty=1 after the 3rd read;
   - underflow set on the 4th request and held through cycle 5 and beyond.
4. Wrap: ADDR_WIDTH=4, advance the write pointer Gray-by-Gray to bin 31 (gray 10000) then bin 32 mod 32 = 0 (gray 00000), reading continuously -> rd_ptr_gray sequence matches, rd_ptr_ram wraps 15->0, and empty is asserted only when the pointers are equal.
5. Full level: write pointer at bin 16 (gray 11000), read pointer at 0 -> rd_level=16, empty=0, almost_empty=0.
6. Simultaneous: level 2, with a read accepted in the same cycle that wr_gray_sync advances by 1 -> rd_level stays 2 and empty stays 0.
